pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined control and hazard unit for the 5-stage RV32I core. Decodes the ID-stage instruction into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers. Resolves branches and jumps in EX, detects load-use and RAW hazards, and drives forwarding selects, stall and flush signals for the datapath. It supersedes the single-cycle combinational decoder and adds JALR, SRA, SLTU and pipeline hazard control.

## Interface
- REG_AW, 5: register address width (4 for RV32E).
- ALUSEL_W, 4: ALU select width, minimum 4.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_instr  in  32  instruction in ID.
- id_valid  in  1  ID instruction valid.
- ex_br_eq, ex_br_lt  in  1 each  branch comparator results for the EX instruction.
- stall_ext  in  1  memory wait; freezes the whole pipeline.
- ex_asel, ex_bsel, ex_brun  out  1 each  EX operand selects; brun=1 selects unsigned compare.
- ex_alusel  out  ALUSEL_W  ALU op. Encoding: add 0, sub 1, and 2, or 3, xor 4, sll 5, srl 6, lui 7, slt 8, auipc 9, sra 10, sltu 11.
- ex_fwd_a, ex_fwd_b  out  2 each  operand forward select: 00 RF, 01 EX/MEM, 10 MEM/WB.
- mem_memrw  out  1  store enable.
- mem_funct3  out  3  access size/sign.
- wb_regwen  out  1  register write enable.
- wb_wbsel  out  2  writeback source: 00 mem, 01 ALU, 10 PC+4.
- wb_rd  out  REG_AW  destination register.
- pc_sel  out  1  take EX target.
- pc_stall, if_id_stall, if_id_flush  out  1 each  front-end control.

## Operation
- Decode is combinational on id_instr. Supported opcodes: R, I-ALU, load, store, branch, JAL, JALR (1100111), LUI, AUIPC. Any other opcode, or id_valid=0, produces a bubble (regwen=0, memrw=0, not a branch).
- Branch outcomes: beq taken on br_eq; bne taken on !br_eq; blt/bltu taken on br_lt; bge/bgeu taken on !br_lt. brun=1 only for bltu/bgeu.
- pc_sel=1 when the EX stage holds a valid taken branch, JAL or JALR. JALR uses ex_asel=0 (rs1). JAL and branches use ex_asel=1 (PC).
- On pc_sel=1: if_id_flush=1 in the same cycle, and ID/EX loads a bubble at the next edge. Penalty is 2 cycles.
- Load-use: when ID/EX holds a load with rd≠0 that matches an ID rs1/rs2 the instruction actually uses, pc_stall=if_id_stall=1 for one cycle and ID/EX loads a bubble.
- Forwarding applies to EX rs1/rs2 when the source is valid and rd≠0 and matches. EX/MEM has priority over MEM/WB.
- Simultaneous events:
  - pc_sel overrides load-use. No stall is asserted, and the flush wins.
  - stall_ext=1 holds all stage registers and forces pc_stall=if_id_stall=1.
  - While stall_ext=1, pc_sel is still driven, but if_id_flush is suppressed until stall_ext=0.
- x0 is never a hazard source.

## Timing
- Reset (async, rst_n=0): all stage registers become bubbles.
  - All outputs read 0: pc_sel, all stalls, flush, regwen, memrw, fwd=00, wb_rd=0, alusel=0.
- Stage registers advance on the rising clk edge when stall_ext=0.
- Latency from ID decode to outputs:
  - ex_* controls: 1 cycle.
  - mem_* controls: 2 cycles.
  - wb_* controls: 3 cycles.
- pc_sel, fwd, stall and flush are combinational from the stage registers and inputs within the cycle. They are not registered.
- Reset asserted mid-operation discards all in-flight instructions. There is no replay.

## Configuration
- CTRL_FWD_EN defined: the forwarding network is present, and only load-use stalls.
- CTRL_FWD_EN undefined: ex_fwd_a/b are tied to 00. The unit interlocks instead, asserting pc_stall/if_id_stall and a bubble while any used ID source matches a writing rd≠0 in ID/EX or EX/MEM. MEM/WB is covered by the write-first register file.

## Test plan
- Reset mid-stream: rst_n=0 while three instructions are in flight -> all outputs 0 immediately; no register writes follow after release.
- add x3,x1,x2 followed by sub x4,x3,x1 -> with FWD: ex_fwd_a=01 on sub, no stall. Without FWD: 2 stall cycles, then fwd=00.
- lw x5,0(x1) followed by add x6,x5,x2 -> exactly 1 stall cycle plus 1 bubble, then ex_fwd_a=10.
- beq with ex_br_eq=1 -> pc_sel=1 and if_id_flush=1 in the same cycle; the next ID/EX is a bubble. With ex_br_eq=0 -> no flush.
- bltu with ex_br_lt=1 -> ex_brun=1 and pc_sel=1. jalr x1,0(x2) -> ex_asel=0, pc_sel=1, wb_wbsel=10, wb_rd=1.
- stall_ext=1 for 3 cycles during a taken branch -> stages held, flush deferred, then issued once stall_ext=0.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32I control/hazard unit: decode, ID/EX-EX/MEM-MEM/WB control registers, branch resolution, stalls, flushes.
// Build option CTRL_FWD_EN: forwarding network present (load-use stalls only); undefined -> full RAW interlock.
module pipe_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int ALUSEL_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         id_instr,
  input  logic                id_valid,
  input  logic                ex_br_eq,
  input  logic                ex_br_lt,
  input  logic                stall_ext,
  output logic                ex_asel,
  output logic                ex_bsel,
  output logic                ex_brun,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [1:0]          ex_fwd_a,
  output logic [1:0]          ex_fwd_b,
  output logic                mem_memrw,
  output logic [2:0]          mem_funct3,
  output logic                wb_regwen,
  output logic [1:0]          wb_wbsel,
  output logic [REG_AW-1:0]   wb_rd,
  output logic                pc_sel,
  output logic                pc_stall,
  output logic                if_id_stall,
  output logic                if_id_flush
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
    ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_LUI = 4'd7,
    ALU_SLT = 4'd8, ALU_AUIPC = 4'd9, ALU_SRA = 4'd10, ALU_SLTU = 4'd11
  } alu_op_e;

  // All-zero value of each stage type is a bubble.
  typedef struct packed {
    logic              valid;
    logic              regwen;
    logic              memrw;
    logic [1:0]        wbsel;
    alu_op_e           alusel;
    logic              asel;
    logic              bsel;
    logic              brun;
    logic              is_branch;
    logic              is_jump;
    logic              is_load;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
  } ctrl_t;

  typedef struct packed {
    logic              regwen;
    logic              memrw;
    logic [2:0]        funct3;
    logic [1:0]        wbsel;
    logic [REG_AW-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic              regwen;
    logic [1:0]        wbsel;
    logic [REG_AW-1:0] rd;
  } wb_t;

  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic f7b5, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic reads_reg(input ctrl_t d, input logic [REG_AW-1:0] r);
    return (d.use_rs1 && d.rs1 == r) || (d.use_rs2 && d.rs2 == r);
  endfunction

  ctrl_t dec, idex;
  mem_t  exmem;
  wb_t   memwb;
  logic  br_cond, hazard, stall_hz;

  logic unused_bits;
  assign unused_bits = ^{id_instr[31], id_instr[29:25]};

  // NOTE: every field gets a default before the case so no path leaves a latch behind.
  always_comb begin
    dec        = '0;
    dec.funct3 = id_instr[14:12];
    dec.rd     = id_instr[7 +: REG_AW];
    dec.rs1    = id_instr[15 +: REG_AW];
    dec.rs2    = id_instr[20 +: REG_AW];
    dec.bsel   = 1'b1;
    dec.valid  = id_valid;
    case (id_instr[6:0])
      OP_R: begin
        dec.regwen = 1'b1; dec.wbsel = WB_ALU; dec.bsel = 1'b0;
        dec.alusel = alu_decode(id_instr[14:12], id_instr[30], 1'b1);
        dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1;
      end
      OP_IALU: begin
        dec.regwen = 1'b1; dec.wbsel = WB_ALU; dec.use_rs1 = 1'b1;
        dec.alusel = alu_decode(id_instr[14:12], id_instr[30], 1'b0);
      end
      OP_LOAD: begin
        dec.regwen = 1'b1; dec.wbsel = WB_MEM; dec.is_load = 1'b1; dec.use_rs1 = 1'b1;
      end
      OP_STORE: begin
        dec.memrw = 1'b1; dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1;
      end
      OP_BR: begin
        dec.is_branch = 1'b1; dec.asel = 1'b1; dec.brun = id_instr[13];
        dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1;
      end
      OP_JAL: begin
        dec.regwen = 1'b1; dec.wbsel = WB_PC4; dec.is_jump = 1'b1; dec.asel = 1'b1;
      end
      OP_JALR: begin
        dec.regwen = 1'b1; dec.wbsel = WB_PC4; dec.is_jump = 1'b1; dec.use_rs1 = 1'b1;
      end
      OP_LUI:   begin dec.regwen = 1'b1; dec.wbsel = WB_ALU; dec.alusel = ALU_LUI; end
      OP_AUIPC: begin
        dec.regwen = 1'b1; dec.wbsel = WB_ALU; dec.alusel = ALU_AUIPC; dec.asel = 1'b1;
      end
      default:  dec.valid = 1'b0;
    endcase
    if (!dec.regwen) dec.rd = '0;
    if (!dec.valid)  dec = '0;
  end

  always_comb begin
    case (idex.funct3)
      3'b000:         br_cond = ex_br_eq;
      3'b001:         br_cond = !ex_br_eq;
      3'b100, 3'b110: br_cond = ex_br_lt;
      3'b101, 3'b111: br_cond = !ex_br_lt;
      default:        br_cond = 1'b0;
    endcase
  end

  assign pc_sel = idex.valid && (idex.is_jump || (idex.is_branch && br_cond));

`ifdef CTRL_FWD_EN
  assign hazard = idex.is_load && (idex.rd != '0) && reads_reg(dec, idex.rd);

  // rd is zeroed for non-writers, so a nonzero source match implies a real producer.
  always_comb begin
    ex_fwd_a = 2'b00;
    ex_fwd_b = 2'b00;
    if (idex.use_rs1 && idex.rs1 != '0) begin
      if (exmem.regwen && exmem.rd == idex.rs1)      ex_fwd_a = 2'b01;
      else if (memwb.regwen && memwb.rd == idex.rs1) ex_fwd_a = 2'b10;
    end
    if (idex.use_rs2 && idex.rs2 != '0) begin
      if (exmem.regwen && exmem.rd == idex.rs2)      ex_fwd_b = 2'b01;
      else if (memwb.regwen && memwb.rd == idex.rs2) ex_fwd_b = 2'b10;
    end
  end
`else
  // MEM/WB needs no interlock: the register file writes before it reads.
  assign hazard = (idex.regwen && (idex.rd != '0) && reads_reg(dec, idex.rd)) ||
                  (exmem.regwen && (exmem.rd != '0) && reads_reg(dec, exmem.rd));
  assign ex_fwd_a = 2'b00;
  assign ex_fwd_b = 2'b00;

  logic unused_fwd;
  assign unused_fwd = ^{idex.rs1, idex.rs2, idex.use_rs1, idex.use_rs2, idex.is_load};
`endif

  assign stall_hz    = hazard && !pc_sel;
  assign pc_stall    = stall_ext || stall_hz;
  assign if_id_stall = stall_ext || stall_hz;
  assign if_id_flush = pc_sel && !stall_ext;

  // NOTE: state registers use non-blocking assignments so every stage samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else if (!stall_ext) begin
      idex         <= (pc_sel || hazard) ? '0 : dec;
      exmem.regwen <= idex.regwen;
      exmem.memrw  <= idex.memrw;
      exmem.funct3 <= idex.funct3;
      exmem.wbsel  <= idex.wbsel;
      exmem.rd     <= idex.rd;
      memwb.regwen <= exmem.regwen;
      memwb.wbsel  <= exmem.wbsel;
      memwb.rd     <= exmem.rd;
    end
  end

  assign ex_asel    = idex.asel;
  assign ex_bsel    = idex.bsel;
  assign ex_brun    = idex.brun;
  assign ex_alusel  = ALUSEL_W'(idex.alusel);
  assign mem_memrw  = exmem.memrw;
  assign mem_funct3 = exmem.funct3;
  assign wb_regwen  = memwb.regwen;
  assign wb_wbsel   = memwb.wbsel;
  assign wb_rd      = memwb.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed testbench for pipe_ctrl_unit; expectations follow CTRL_FWD_EN when defined.
module tb_pipe_ctrl_unit;

  logic        clk, rst_n, id_valid, ex_br_eq, ex_br_lt, stall_ext;
  logic [31:0] id_instr;
  logic        ex_asel, ex_bsel, ex_brun, mem_memrw, wb_regwen;
  logic        pc_sel, pc_stall, if_id_stall, if_id_flush;
  logic [3:0]  ex_alusel;
  logic [1:0]  ex_fwd_a, ex_fwd_b, wb_wbsel;
  logic [2:0]  mem_funct3;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  pipe_ctrl_unit #(.REG_AW(5), .ALUSEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .ex_br_eq(ex_br_eq), .ex_br_lt(ex_br_lt), .stall_ext(stall_ext),
    .ex_asel(ex_asel), .ex_bsel(ex_bsel), .ex_brun(ex_brun), .ex_alusel(ex_alusel),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .mem_memrw(mem_memrw), .mem_funct3(mem_funct3),
    .wb_regwen(wb_regwen), .wb_wbsel(wb_wbsel), .wb_rd(wb_rd), .pc_sel(pc_sel),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {7'b0, rs2, rs1, f3, 5'b0, 7'b1100011};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins);
    id_valid = v;
    id_instr = ins;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 32'h0);
    repeat (n) next();
  endtask

  task automatic branch_case(input string tag, input logic [2:0] f3, input logic eq, input logic lt,
                             input logic exp_sel, input logic exp_brun);
    drive(1'b1, enc_b(5'd2, 5'd1, f3));
    next();
    drive(1'b1, enc_i(12'd5, 5'd1, 3'b000, 5'd7, 7'b0010011));
    ex_br_eq = eq;
    ex_br_lt = lt;
    sample();
    check({tag, "_pc_sel"}, pc_sel, exp_sel);
    check({tag, "_flush"}, if_id_flush, exp_sel);
    check({tag, "_brun"}, ex_brun, exp_brun);
    next();
    drive(1'b0, 32'h0);
    ex_br_eq = 1'b0;
    ex_br_lt = 1'b0;
    sample();
    check({tag, "_next_ex_bsel"}, ex_bsel, exp_sel ? 1'b0 : 1'b1);
    idle(3);
  endtask

  logic [31:0] add_x3, sub_x4, lw_x5, add_x6, lw_x0, add_x6_x0, lui_x6, jalr_x1, jal_x1;
  logic [31:0] addi_x7, addi_x8, ori_x9;

  initial begin
    add_x3    = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    sub_x4    = enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd4);
    lw_x5     = enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011);
    add_x6    = enc_r(7'h00, 5'd2, 5'd5, 3'b000, 5'd6);
    lw_x0     = enc_i(12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011);
    add_x6_x0 = enc_r(7'h00, 5'd2, 5'd0, 3'b000, 5'd6);
    lui_x6    = {12'h000, 5'd5, 3'b000, 5'd6, 7'b0110111};
    jalr_x1   = enc_i(12'd0, 5'd2, 3'b000, 5'd1, 7'b1100111);
    jal_x1    = {20'h0, 5'd1, 7'b1101111};
    addi_x7   = enc_i(12'd5, 5'd1, 3'b000, 5'd7, 7'b0010011);
    addi_x8   = enc_i(12'd6, 5'd1, 3'b000, 5'd8, 7'b0010011);
    ori_x9    = enc_i(12'd1, 5'd1, 3'b110, 5'd9, 7'b0010011);

    rst_n = 1'b0; ex_br_eq = 1'b0; ex_br_lt = 1'b0; stall_ext = 1'b0;
    drive(1'b0, 32'h0);
    #2;
    check("rst_pc_sel", pc_sel, 0);
    check("rst_pc_stall", pc_stall, 0);
    check("rst_if_id_stall", if_id_stall, 0);
    check("rst_flush", if_id_flush, 0);
    check("rst_regwen", wb_regwen, 0);
    check("rst_memrw", mem_memrw, 0);
    check("rst_fwd", {ex_fwd_a, ex_fwd_b}, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_alusel", ex_alusel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next();
    idle(2);

    // RAW on the ALU result
    drive(1'b1, add_x3); sample(); check("add_nostall", pc_stall, 0); next();
    drive(1'b1, sub_x4); sample();
`ifdef CTRL_FWD_EN
    check("sub_nostall", pc_stall, 0); next();
    drive(1'b0, 32'h0); sample();
    check("sub_fwd_a", ex_fwd_a, 2'b01);
    check("sub_fwd_b", ex_fwd_b, 2'b00);
    check("sub_alusel", ex_alusel, 1);
    next(); sample();
`else
    check("sub_stall1", pc_stall, 1); check("sub_ifid_stall1", if_id_stall, 1); next();
    sample(); check("sub_stall2", pc_stall, 1); next();
    sample(); check("sub_release", pc_stall, 0);
`endif
    check("add_wb_rd", wb_rd, 3);
    check("add_wb_regwen", wb_regwen, 1);
    check("add_wb_wbsel", wb_wbsel, 2'b01);
`ifndef CTRL_FWD_EN
    next(); drive(1'b0, 32'h0); sample();
    check("sub_alusel", ex_alusel, 1);
    check("sub_fwd_a", ex_fwd_a, 2'b00);
`endif
    idle(3);

    // load-use
    drive(1'b1, lw_x5); sample(); check("lw_nostall", pc_stall, 0); next();
    drive(1'b1, add_x6); sample();
    check("lu_stall", pc_stall, 1); check("lu_ifid_stall", if_id_stall, 1); check("lu_noflush", if_id_flush, 0);
    next(); sample();
    check("lu_mem_funct3", mem_funct3, 3'b010);
    check("lu_mem_memrw", mem_memrw, 0);
`ifdef CTRL_FWD_EN
    check("lu_release", pc_stall, 0);
    next(); drive(1'b0, 32'h0); sample();
    check("lu_fwd_a", ex_fwd_a, 2'b10);
    check("lu_fwd_b", ex_fwd_b, 2'b00);
`else
    check("lu_stall2", pc_stall, 1);
    next(); sample();
    check("lu_release", pc_stall, 0);
`endif
    check("lw_wb_rd", wb_rd, 5);
    check("lw_wb_wbsel", wb_wbsel, 2'b00);
    check("lw_wb_regwen", wb_regwen, 1);
    idle(3);

    // x0 never a hazard source; LUI reads no register
    drive(1'b1, lw_x0); next();
    drive(1'b1, add_x6_x0); sample(); check("x0_nostall", pc_stall, 0); next();
    drive(1'b0, 32'h0); sample(); check("x0_fwd_a", ex_fwd_a, 2'b00);
    idle(3);
    drive(1'b1, lw_x5); next();
    drive(1'b1, lui_x6); sample(); check("lui_nostall", pc_stall, 0);
    idle(3);

    // unsupported opcode becomes a bubble
    drive(1'b1, 32'hFFFF_FFFF); next();
    drive(1'b0, 32'h0); sample(); check("bad_op_bsel", ex_bsel, 0); check("bad_op_pc_sel", pc_sel, 0);
    next(); next(); sample(); check("bad_op_regwen", wb_regwen, 0);
    idle(2);

    branch_case("beq_t",  3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    branch_case("beq_nt", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    branch_case("bne_t",  3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
    branch_case("bltu_t", 3'b110, 1'b0, 1'b1, 1'b1, 1'b1);
    branch_case("bge_nt", 3'b101, 1'b0, 1'b1, 1'b0, 1'b0);

    drive(1'b1, jalr_x1); next();
    drive(1'b0, 32'h0); sample();
    check("jalr_asel", ex_asel, 0); check("jalr_pc_sel", pc_sel, 1); check("jalr_flush", if_id_flush, 1);
    next(); next(); sample();
    check("jalr_wbsel", wb_wbsel, 2'b10); check("jalr_wb_rd", wb_rd, 1); check("jalr_regwen", wb_regwen, 1);
    idle(3);
    drive(1'b1, jal_x1); next();
    drive(1'b0, 32'h0); sample();
    check("jal_asel", ex_asel, 1); check("jal_pc_sel", pc_sel, 1);
    idle(3);

    // external stall during a taken branch
    drive(1'b1, enc_b(5'd2, 5'd1, 3'b000)); next();
    drive(1'b1, addi_x7); ex_br_eq = 1'b1; stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("ext_pc_sel_%0d", i), pc_sel, 1);
      check($sformatf("ext_flush_%0d", i), if_id_flush, 0);
      check($sformatf("ext_stall_%0d", i), {pc_stall, if_id_stall}, 2'b11);
      check($sformatf("ext_held_asel_%0d", i), ex_asel, 1);
      next();
    end
    stall_ext = 1'b0; sample();
    check("ext_flush_release", if_id_flush, 1); check("ext_pc_sel_release", pc_sel, 1);
    check("ext_nostall_release", pc_stall, 0);
    next(); drive(1'b0, 32'h0); ex_br_eq = 1'b0; sample();
    check("ext_bubble_bsel", ex_bsel, 0); check("ext_bubble_pc_sel", pc_sel, 0);
    idle(3);

    // reset with three instructions in flight
    drive(1'b1, addi_x7); next();
    drive(1'b1, addi_x8); next();
    drive(1'b1, ori_x9); next();
    drive(1'b0, 32'h0); sample();
    check("pre_rst_wb_rd", wb_rd, 7); check("pre_rst_alusel", ex_alusel, 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_regwen", wb_regwen, 0); check("mid_rst_wb_rd", wb_rd, 0);
    check("mid_rst_alusel", ex_alusel, 0); check("mid_rst_bsel", ex_bsel, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next(); sample();
      check($sformatf("post_rst_regwen_%0d", i), wb_regwen, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
